// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU operation codes and ALUOp encodings,
// used by id_ex_stage, alu_control and the alu.
package riscv_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } alu_op_e;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_control.sv
// Combinational ALU control: maps (alu_op, funct3, funct7b5) to the 4-bit ALU
// operation and flags combinations the ALU does not implement as illegal.
module alu_control
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] operation,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        operation = ALU_NOP;
        illegal   = 1'b1;
        case (alu_op)
            ALUOP_MEM: begin
                operation = ALU_ADD;
                illegal   = 1'b0;
            end
            ALUOP_BRANCH: begin
                operation = ALU_SUB;
                illegal   = 1'b0;
            end
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                case (funct3)
                    F3_AND: begin
                        operation = ALU_AND;
                        illegal   = 1'b0;
                    end
                    F3_OR: begin
                        operation = ALU_OR;
                        illegal   = 1'b0;
                    end
                    F3_ADD: begin
                        // funct7b5 selects SUB only for register-register ops; ADDI has no SUBI.
                        operation = (alu_op == ALUOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                        illegal   = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU. Define ID_EX_FWD_EN to enable
// EX/MEM and MEM/WB operand forwarding; otherwise register-file data is used.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rs1_data,
    input  logic [WIDTH-1:0] id_rs2_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [1:0]       id_alu_op,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7b5,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             exmem_reg_write,
    input  logic [4:0]       exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [4:0]       memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic             ex_valid,
    output logic [3:0]       operation,
    output logic [WIDTH-1:0] data1,
    output logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_illegal
);

    logic [3:0]       dec_op;
    logic             dec_illegal;

    logic             valid_q, illegal_q, alu_src_q;
    logic             reg_write_q, mem_read_q, mem_write_q;
    logic [3:0]       op_q;
    logic [4:0]       rd_q;
    logic [WIDTH-1:0] rs1_data_q, rs2_data_q, imm_q;
    logic [WIDTH-1:0] rs1_val, rs2_val;

    alu_control u_alu_control (
        .alu_op    (id_alu_op),
        .funct3    (id_funct3),
        .funct7b5  (id_funct7b5),
        .operation (dec_op),
        .illegal   (dec_illegal)
    );

`ifdef ID_EX_FWD_EN
    logic [4:0] rs1_q, rs2_q;
`endif

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            valid_q     <= 1'b0;
            op_q        <= ALU_ADD;
            illegal_q   <= 1'b0;
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
`ifdef ID_EX_FWD_EN
            rs1_q       <= '0;
            rs2_q       <= '0;
`endif
        end else if (flush) begin
            // Bubble: control cleared, operand data left as-is since nothing consumes it.
            valid_q     <= 1'b0;
            op_q        <= ALU_ADD;
            illegal_q   <= 1'b0;
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rd_q        <= '0;
        end else if (!stall) begin
            valid_q     <= id_valid;
            op_q        <= dec_op;
            illegal_q   <= dec_illegal;
            alu_src_q   <= id_alu_src;
            reg_write_q <= id_reg_write;
            mem_read_q  <= id_mem_read;
            mem_write_q <= id_mem_write;
            rd_q        <= id_rd;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
`ifdef ID_EX_FWD_EN
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
`endif
        end
    end

`ifdef ID_EX_FWD_EN
    function automatic logic [WIDTH-1:0] fwd(
        input logic [4:0]       rs,
        input logic [WIDTH-1:0] rf_data,
        input logic             em_we,
        input logic [4:0]       em_rd,
        input logic [WIDTH-1:0] em_res,
        input logic             mw_we,
        input logic [4:0]       mw_rd,
        input logic [WIDTH-1:0] mw_res
    );
        if (rs != 5'd0 && em_we && em_rd == rs) return em_res;
        if (rs != 5'd0 && mw_we && mw_rd == rs) return mw_res;
        return rf_data;
    endfunction

    always_comb begin
        rs1_val = fwd(rs1_q, rs1_data_q, exmem_reg_write, exmem_rd, exmem_result,
                      memwb_reg_write, memwb_rd, memwb_result);
        rs2_val = fwd(rs2_q, rs2_data_q, exmem_reg_write, exmem_rd, exmem_result,
                      memwb_reg_write, memwb_rd, memwb_result);
    end

    logic unused_ids;
    assign unused_ids = 1'b0;
`else
    assign rs1_val = rs1_data_q;
    assign rs2_val = rs2_data_q;

    logic unused_ids;
    assign unused_ids = ^{id_rs1, id_rs2, exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result};
`endif

    assign data1         = rs1_val;
    assign ex_store_data = rs2_val;
    assign data2         = alu_src_q ? imm_q : rs2_val;

    // Side-effecting controls only escape for a valid, legal instruction.
    assign ex_valid     = valid_q;
    assign operation    = op_q;
    assign ex_rd        = rd_q;
    assign ex_illegal   = valid_q & illegal_q;
    assign ex_reg_write = reg_write_q & valid_q & ~illegal_q;
    assign ex_mem_read  = mem_read_q  & valid_q & ~illegal_q;
    assign ex_mem_write = mem_write_q & valid_q & ~illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases plus random stimulus
// against a behavioural model; honours ID_EX_FWD_EN when defined.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [63:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  id_alu_op;
    logic [2:0]  id_funct3;
    logic        id_funct7b5, id_alu_src, id_reg_write, id_mem_read, id_mem_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [63:0] exmem_result, memwb_result;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;
    logic [3:0]  operation;
    logic [63:0] data1, data2, ex_store_data;
    logic [4:0]  ex_rd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .operation(operation), .data1(data1), .data2(data2),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_illegal(ex_illegal)
    );

    // Expected contents of the stage; dv=0 means operand data is don't-care (after a bubble).
    typedef struct {
        bit        valid, ill, src, rw, mr, mw, dv;
        bit [3:0]  op;
        bit [4:0]  rd, rs1, rs2;
        bit [63:0] r1, r2, imm;
    } model_t;

    model_t m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns {illegal, operation} from the decode table.
    function automatic bit [4:0] m_decode(input bit [1:0] aop, input bit [2:0] f3, input bit f7);
        if (aop == 2'd0) return {1'b0, 4'd2};
        if (aop == 2'd1) return {1'b0, 4'd6};
        if (f3 == 3'd7) return {1'b0, 4'd0};
        if (f3 == 3'd6) return {1'b0, 4'd1};
        if (f3 == 3'd0) return {1'b0, (aop == 2'd2 && f7) ? 4'd6 : 4'd2};
        return {1'b1, 4'd15};
    endfunction

    function automatic bit [63:0] m_fwd(input bit [4:0] rs, input bit [63:0] rf);
        if (rs == 5'd0) return rf;
`ifdef ID_EX_FWD_EN
        if (exmem_reg_write && exmem_rd == rs) return exmem_result;
        if (memwb_reg_write && memwb_rd == rs) return memwb_result;
`endif
        return rf;
    endfunction

    task automatic model_update();
        bit [4:0] d;
        if (reset) begin
            m = '{valid: 0, ill: 0, src: 0, rw: 0, mr: 0, mw: 0, dv: 1, op: 4'd2,
                  rd: 0, rs1: 0, rs2: 0, r1: 0, r2: 0, imm: 0};
        end else if (flush) begin
            m.valid = 0; m.ill = 0; m.src = 0; m.rw = 0; m.mr = 0; m.mw = 0;
            m.rd = 0; m.op = 4'd2; m.dv = 0;
        end else if (!stall) begin
            d = m_decode(id_alu_op, id_funct3, id_funct7b5);
            m.valid = id_valid; m.ill = d[4]; m.op = d[3:0]; m.src = id_alu_src;
            m.rw = id_reg_write; m.mr = id_mem_read; m.mw = id_mem_write;
            m.rd = id_rd; m.rs1 = id_rs1; m.rs2 = id_rs2;
            m.r1 = id_rs1_data; m.r2 = id_rs2_data; m.imm = id_imm; m.dv = 1;
        end
    endtask

    task automatic compare_all();
        bit ok;
        ok = m.valid && !m.ill;
        check("ex_valid", ex_valid, m.valid);
        check("operation", operation, m.op);
        check("ex_rd", ex_rd, m.rd);
        check("ex_illegal", ex_illegal, m.valid && m.ill);
        check("ex_reg_write", ex_reg_write, ok && m.rw);
        check("ex_mem_read", ex_mem_read, ok && m.mr);
        check("ex_mem_write", ex_mem_write, ok && m.mw);
        if (m.dv) begin
            check("data1", data1, m_fwd(m.rs1, m.r1));
            check("ex_store_data", ex_store_data, m_fwd(m.rs2, m.r2));
            check("data2", data2, m.src ? m.imm : m_fwd(m.rs2, m.r2));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        reset = 0; stall = 0; flush = 0; id_valid = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_op = 0; id_funct3 = 0;
        id_funct7b5 = 0; id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic randomize_id();
        id_valid     = ($urandom_range(0, 7) != 0);
        id_rs1_data  = {$urandom, $urandom};
        id_rs2_data  = {$urandom, $urandom};
        id_imm       = {$urandom, $urandom};
        id_rs1       = 5'($urandom_range(0, 7));
        id_rs2       = 5'($urandom_range(0, 7));
        id_rd        = 5'($urandom);
        id_alu_op    = 2'($urandom);
        case ($urandom_range(0, 3))
            0: id_funct3 = 3'd0;
            1: id_funct3 = 3'd6;
            2: id_funct3 = 3'd7;
            default: id_funct3 = 3'($urandom);
        endcase
        id_funct7b5  = 1'($urandom);
        id_alu_src   = 1'($urandom);
        id_reg_write = 1'($urandom);
        id_mem_read  = 1'($urandom);
        id_mem_write = 1'($urandom);
    endtask

    task automatic randomize_fwd();
        exmem_reg_write = 1'($urandom);
        exmem_rd        = 5'($urandom_range(0, 7));
        exmem_result    = {$urandom, $urandom};
        memwb_reg_write = 1'($urandom);
        memwb_rd        = 5'($urandom_range(0, 7));
        memwb_result    = {$urandom, $urandom};
    endtask

    initial begin
        clear_inputs();
        m = '{valid: 0, ill: 0, src: 0, rw: 0, mr: 0, mw: 0, dv: 0, op: 4'd2,
              rd: 0, rs1: 0, rs2: 0, r1: 0, r2: 0, imm: 0};

        // Reset state
        reset = 1;
        tick();
        tick();
        check("rst_operation", operation, 64'h2);
        check("rst_data1", data1, 64'h0);
        reset = 0;

        // R-type SUB
        id_valid = 1; id_alu_op = 2'b10; id_funct3 = 3'b000; id_funct7b5 = 1;
        id_rs1_data = 64'd10; id_rs2_data = 64'd3; id_rs1 = 5'd1; id_rs2 = 5'd2;
        id_rd = 5'd4; id_reg_write = 1;
        tick();
        check("sub_operation", operation, 64'h6);
        check("sub_data1", data1, 64'd10);
        check("sub_data2", data2, 64'd3);
        check("sub_reg_write", ex_reg_write, 64'd1);

        // I-type ORI
        id_alu_op = 2'b11; id_funct3 = 3'b110; id_funct7b5 = 0; id_alu_src = 1;
        id_imm = 64'hF0; id_rs1_data = 64'h0F;
        tick();
        check("ori_operation", operation, 64'h1);
        check("ori_data1", data1, 64'h0F);
        check("ori_data2", data2, 64'hF0);

        // Stall while ID inputs change: stage holds the ORI
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            randomize_id();
            tick();
            check("stall_operation", operation, 64'h1);
            check("stall_data2", data2, 64'hF0);
        end

        // Stall and flush together: bubble
        id_valid = 1; id_reg_write = 1; flush = 1;
        tick();
        check("flush_valid", ex_valid, 64'd0);
        check("flush_reg_write", ex_reg_write, 64'd0);
        stall = 0; flush = 0;

        // Illegal combination
        clear_inputs();
        id_valid = 1; id_alu_op = 2'b10; id_funct3 = 3'b010;
        id_reg_write = 1; id_mem_write = 1;
        tick();
        check("ill_operation", operation, 64'hF);
        check("ill_flag", ex_illegal, 64'd1);
        check("ill_reg_write", ex_reg_write, 64'd0);
        check("ill_mem_write", ex_mem_write, 64'd0);

        // Reset asserted mid-stall with a valid instruction held
        clear_inputs();
        id_valid = 1; id_alu_op = 2'b00; id_rs1_data = 64'h1234; id_rs2_data = 64'h5678;
        id_rd = 5'd9; id_reg_write = 1; id_mem_read = 1;
        tick();
        stall = 1;
        tick();
        reset = 1;
        tick();
        check("rstst_valid", ex_valid, 64'd0);
        check("rstst_operation", operation, 64'h2);
        check("rstst_data1", data1, 64'd0);
        check("rstst_data2", data2, 64'd0);
        check("rstst_store", ex_store_data, 64'd0);
        check("rstst_rd", ex_rd, 64'd0);
        check("rstst_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal}, 64'd0);
        reset = 0; stall = 0;

`ifdef ID_EX_FWD_EN
        // Forwarding priority and x0 exclusion
        clear_inputs();
        id_valid = 1; id_rs1 = 5'd5; id_rs1_data = 64'h11; id_rs2 = 5'd0; id_rs2_data = 64'h22;
        tick();
        stall = 1;
        exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 64'hAA;
        memwb_reg_write = 1; memwb_rd = 5'd5; memwb_result = 64'hBB;
        #1;
        check("fwd_exmem_prio", data1, 64'hAA);
        exmem_reg_write = 0;
        #1;
        check("fwd_memwb", data1, 64'hBB);
        exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 64'hCC;
        memwb_rd = 5'd0;
        #1;
        check("fwd_x0", data2, 64'h22);
        compare_all();
        stall = 0;
        clear_inputs();
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            randomize_id();
            randomize_fwd();
            reset = ($urandom_range(0, 39) == 0);
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the `alu`. It registers decoded operands and control from the decode stage and derives the 4-bit ALU `operation` from ALUOp/funct3/funct7. It drives `data1`, `data2` and `operation` into the ALU and carries destination and memory control on to EX/MEM. Optional operand forwarding resolves RAW hazards from EX/MEM and MEM/WB.

## Interface
- `WIDTH`, 64: datapath width.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold the stage contents.
- `flush` in 1: replace the stage contents with a bubble.
- `id_valid` in 1: the decode-stage instruction is valid.
- `id_rs1_data`, `id_rs2_data`, `id_imm` in WIDTH: register-file reads and the sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd` in 5: register indices.
- `id_alu_op` in 2: 00 load/store, 01 branch, 10 R-type, 11 I-type arithmetic.
- `id_funct3` in 3, `id_funct7b5` in 1: instruction function fields.
- `id_alu_src` in 1: 1 selects the immediate as `data2`.
- `id_reg_write`, `id_mem_read`, `id_mem_write` in 1: control bits.
- `exmem_reg_write` in 1, `exmem_rd` in 5, `exmem_result` in WIDTH: forwarding source (FWD_EN only).
- `memwb_reg_write` in 1, `memwb_rd` in 5, `memwb_result` in WIDTH: forwarding source (FWD_EN only).
- `ex_valid` out 1.
- `operation` out 4: to the ALU.
- `data1`, `data2` out WIDTH: to the ALU.
- `ex_store_data` out WIDTH: rs2 value for stores.
- `ex_rd` out 5.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_illegal` out 1.

## Operation
- **Operation decode** (combinational, on ID inputs; the result is registered):
  - ALUOp 00 → 0010 (ADD).
  - ALUOp 01 → 0110 (SUB).
  - ALUOp 10, funct3 000: funct7b5=0 → 0010; funct7b5=1 → 0110.
  - ALUOp 10 or 11, funct3 111 → 0000 (AND); funct3 110 → 0001 (OR).
  - ALUOp 11, funct3 000 → 0010; funct7b5 is ignored.
  - Any other combination → operation 1111 (ALU outputs 0) and the illegal bit set.
- **Register update priority**, each rising edge:
  1. `reset`: all registers cleared.
  2. `flush`: `ex_valid`=0, all control bits 0, `ex_rd`=0, operation=0010. Flush wins over stall.
  3. `stall`: every register holds.
  4. Otherwise: load the ID inputs; `ex_valid`=`id_valid`.
- **Illegal or invalid instructions**:
  - `ex_reg_write`, `ex_mem_read` and `ex_mem_write` are gated by `ex_valid & ~illegal`.
  - `ex_illegal` = `ex_valid & illegal`.
- **Operand select**:
  - `data1` = fwd(rs1).
  - `ex_store_data` = fwd(rs2).
  - `data2` = `alu_src` ? imm : fwd(rs2).
- **Width rules**: all data paths are WIDTH bits wide. The immediate arrives already sign-extended; no arithmetic is performed in this block.

## Timing
- Latency: one cycle from the ID inputs to the registered outputs.
- With FWD_EN defined, forwarding is combinational within the EX cycle and sees the EX/MEM and MEM/WB values present in that cycle.
- Reset values: `ex_valid` 0, `operation` 0010, `data1`/`data2`/`ex_store_data` 0, `ex_rd` 0, all control bits 0, `ex_illegal` 0.
- A reset asserted while stalled clears the stage; the stall is not honoured.
- An invalid instruction is still registered (data passes through), but its control bits are 0.

## Configuration
- `ID_EX_FWD_EN` defined:
  - fwd(rsX) = `exmem_result` when `exmem_reg_write` and `exmem_rd`==rsX and rsX≠0.
  - Otherwise `memwb_result` under the same rule.
  - Otherwise the registered register-file data.
  - EX/MEM has priority over MEM/WB.
- Undefined: fwd(rsX) = registered register-file data. The forwarding inputs are unused and the rs indices need not be stored.

## Structure
- Shared package `riscv_pkg`: the ALU operation constants `ALU_AND`/`ALU_OR`/`ALU_ADD`/`ALU_SUB`/`ALU_NOP` (0000/0001/0010/0110/1111) and the ALUOp encodings. The same constants are used by `alu`.
- Sub-module `alu_control`: purely combinational decode of (alu_op, funct3, funct7b5) into {operation, illegal}.

## Test plan
- **R-type SUB**: ALUOp 10, funct3 000, f7b5 1, rs1=10, rs2=3 → next cycle `operation`=0110, `data1`=10, `data2`=3, `ex_reg_write`=1.
- **I-type ORI**: ALUOp 11, funct3 110, `alu_src`=1, imm=0xF0, rs1=0x0F → `operation`=0001, `data2`=0xF0.
- **Stall for 3 cycles while ID inputs change**: outputs hold. Stall and flush together → bubble (`ex_valid`=0, controls 0).
- **Illegal combination** (ALUOp 10, funct3 010) → `operation`=1111, `ex_illegal`=1, `ex_reg_write`=0, `ex_mem_write`=0.
- **FWD_EN**:
  - EX/MEM rd=5 (result 0xAA) and MEM/WB rd=5 (result 0xBB), EX rs1=5 → `data1`=0xAA.
  - rd=0 with rs1=0 → no forward.
- **Reset**: reset asserted mid-stall with a valid instruction held → next cycle every output equals its reset value.
